// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM state encoding and parity-mode constants for the serial parity framer
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_accum.sv
// parity_accum: one-bit running-XOR parity register with seed load and accumulate enable
module parity_accum
   import serial_pkg::*;
#(
   parameter bit ODD = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   input  logic din,
   output logic par
);

   localparam logic SEED = ODD ? PAR_ODD : PAR_EVEN;

   logic par_d, par_q;

   // seed on a new frame, otherwise fold in each transmitted bit
   always_comb begin
      par_d = load ? SEED : (en ? (par_q ^ din) : par_q);
   end

   // parity storage, returns to the seed value on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_q <= SEED;
      else        par_q <= par_d;
   end

   assign par = par_q;

endmodule

// File: rtl/serial_parity_tx.sv
// serial_parity_tx: shifts a parallel word out LSB-first and appends a parity beat
module serial_parity_tx
   import serial_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter bit ODD   = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_bit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_d, state_q;
   logic [WIDTH-1:0] shift_d, shift_q;
   logic [CW-1:0]    cnt_d, cnt_q;
   logic             par;
   logic             in_xfer, out_xfer, shift_en;

   // handshake and serial outputs; only out_ready reaches in_ready combinationally
   always_comb begin
      in_ready  = (state_q == IDLE) || ((state_q == PARITY) && out_ready);
      out_valid = state_q != IDLE;
      out_last  = state_q == PARITY;
      busy      = state_q != IDLE;
      out_bit   = (state_q == SHIFT) ? shift_q[0] : ((state_q == PARITY) ? par : 1'b0);
      in_xfer   = in_valid && in_ready;
      out_xfer  = out_valid && out_ready;
      shift_en  = (state_q == SHIFT) && out_xfer;
   end

   // frame sequencing; an accept during the parity beat chains straight into the next frame
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = in_xfer ? SHIFT : IDLE;
         SHIFT:   state_d = (out_xfer && cnt_q == LAST) ? PARITY : SHIFT;
         PARITY:  state_d = out_xfer ? (in_xfer ? SHIFT : IDLE) : PARITY;
         default: state_d = IDLE;
      endcase
   end

   // datapath: load a fresh word, or advance one bit per accepted data beat
   always_comb begin
      shift_d = in_xfer ? in_data : (shift_en ? (shift_q >> 1) : shift_q);
      cnt_d   = in_xfer ? '0 : (shift_en ? cnt_q + CW'(1) : cnt_q);
   end

   // state, shifter and bit counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   parity_accum #(.ODD(ODD)) u_par (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (in_xfer),
      .en    (shift_en),
      .din   (shift_q[0]),
      .par   (par)
   );

endmodule

// File: tb/tb_serial_parity_tx.sv
// tb_serial_parity_tx: scoreboard bench over even, odd and two-bit framer instances
module tb_serial_parity_tx;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   logic [7:0] in_data0 = '0, in_data1 = '0;
   logic [1:0] in_data2 = '0;
   logic in_valid0 = 0, in_valid1 = 0, in_valid2 = 0;
   logic out_ready0 = 1, out_ready1 = 1, out_ready2 = 1;
   logic in_ready0, in_ready1, in_ready2;
   logic out_bit0, out_bit1, out_bit2;
   logic out_valid0, out_valid1, out_valid2;
   logic out_last0, out_last1, out_last2;
   logic busy0, busy1, busy2;

   serial_parity_tx #(.WIDTH(8), .ODD(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
      .out_bit(out_bit0), .out_valid(out_valid0), .out_ready(out_ready0), .out_last(out_last0), .busy(busy0));
   serial_parity_tx #(.WIDTH(8), .ODD(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
      .out_bit(out_bit1), .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1), .busy(busy1));
   serial_parity_tx #(.WIDTH(2), .ODD(1'b0)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
      .out_bit(out_bit2), .out_valid(out_valid2), .out_ready(out_ready2), .out_last(out_last2), .busy(busy2));

   // expected beats as {bit, last}
   logic [1:0] sb0[$], sb1[$], sb2[$];
   int beats0 = 0, beats1 = 0, beats2 = 0;
   logic last_par0 = 0, last_par1 = 0, last_par2 = 0;
   logic stall0 = 0, pb0 = 0, pl0 = 0;

   // instance 0 monitor: scoreboard push on accept, pop on beat, stall stability
   always @(negedge clk) begin
      if (!rst_n) stall0 = 0;
      else begin
         if (stall0) begin
            n_checks++;
            if (out_valid0 !== 1'b1 || out_bit0 !== pb0 || out_last0 !== pl0) begin
               n_fail++;
               $display("FAIL stall0: got v=%b b=%b l=%b want v=1 b=%b l=%b", out_valid0, out_bit0, out_last0, pb0, pl0);
            end
         end
         if (in_valid0 && in_ready0) begin
            for (int i = 0; i < 8; i++) sb0.push_back({in_data0[i], 1'b0});
            sb0.push_back({^in_data0, 1'b1});
         end
         if (out_valid0 && out_ready0) begin
            logic [1:0] e;
            n_checks++;
            if (sb0.size() == 0) begin
               n_fail++;
               $display("FAIL beat0: got unexpected b=%b l=%b want no beat", out_bit0, out_last0);
            end else begin
               e = sb0.pop_front();
               if ({out_bit0, out_last0} !== e) begin
                  n_fail++;
                  $display("FAIL beat0: got b=%b l=%b want b=%b l=%b", out_bit0, out_last0, e[1], e[0]);
               end
            end
            if (out_last0) last_par0 = out_bit0;
            beats0++;
         end
         stall0 = out_valid0 && !out_ready0;
         pb0 = out_bit0;
         pl0 = out_last0;
      end
   end

   // instance 1 monitor (odd parity)
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid1 && in_ready1) begin
            for (int i = 0; i < 8; i++) sb1.push_back({in_data1[i], 1'b0});
            sb1.push_back({~^in_data1, 1'b1});
         end
         if (out_valid1 && out_ready1) begin
            logic [1:0] e;
            n_checks++;
            if (sb1.size() == 0) begin
               n_fail++;
               $display("FAIL beat1: got unexpected b=%b l=%b want no beat", out_bit1, out_last1);
            end else begin
               e = sb1.pop_front();
               if ({out_bit1, out_last1} !== e) begin
                  n_fail++;
                  $display("FAIL beat1: got b=%b l=%b want b=%b l=%b", out_bit1, out_last1, e[1], e[0]);
               end
            end
            if (out_last1) last_par1 = out_bit1;
            beats1++;
         end
      end
   end

   // instance 2 monitor (two-bit words)
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid2 && in_ready2) begin
            for (int i = 0; i < 2; i++) sb2.push_back({in_data2[i], 1'b0});
            sb2.push_back({^in_data2, 1'b1});
         end
         if (out_valid2 && out_ready2) begin
            logic [1:0] e;
            n_checks++;
            if (sb2.size() == 0) begin
               n_fail++;
               $display("FAIL beat2: got unexpected b=%b l=%b want no beat", out_bit2, out_last2);
            end else begin
               e = sb2.pop_front();
               if ({out_bit2, out_last2} !== e) begin
                  n_fail++;
                  $display("FAIL beat2: got b=%b l=%b want b=%b l=%b", out_bit2, out_last2, e[1], e[0]);
               end
            end
            if (out_last2) last_par2 = out_bit2;
            beats2++;
         end
      end
   end

   task automatic send0(input logic [7:0] d);
      int n = 0;
      in_data0 = d;
      in_valid0 = 1;
      @(negedge clk);
      while (!in_ready0 && n < 200) begin @(negedge clk); n++; end
      if (!in_ready0) begin n_checks++; n_fail++; $display("FAIL send0_timeout: got in_ready=0 want 1"); end
      @(posedge clk); #1 in_valid0 = 0;
   endtask

   task automatic send1(input logic [7:0] d);
      int n = 0;
      in_data1 = d;
      in_valid1 = 1;
      @(negedge clk);
      while (!in_ready1 && n < 200) begin @(negedge clk); n++; end
      if (!in_ready1) begin n_checks++; n_fail++; $display("FAIL send1_timeout: got in_ready=0 want 1"); end
      @(posedge clk); #1 in_valid1 = 0;
   endtask

   task automatic send2(input logic [1:0] d);
      int n = 0;
      in_data2 = d;
      in_valid2 = 1;
      @(negedge clk);
      while (!in_ready2 && n < 200) begin @(negedge clk); n++; end
      if (!in_ready2) begin n_checks++; n_fail++; $display("FAIL send2_timeout: got in_ready=0 want 1"); end
      @(posedge clk); #1 in_valid2 = 0;
   endtask

   task automatic wait_idle(input int which);
      int n = 0;
      bit done = 0;
      while (!done && n < 400) begin
         @(negedge clk); #1;
         n++;
         case (which)
            0: done = sb0.size() == 0 && !busy0;
            1: done = sb1.size() == 0 && !busy1;
            default: done = sb2.size() == 0 && !busy2;
         endcase
      end
      if (!done) begin n_checks++; n_fail++; $display("FAIL drain%0d_timeout: got busy want idle", which); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      #1;
      n_checks++;
      if ({in_ready0, out_valid0, out_bit0, out_last0, busy0} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 10000", {in_ready0, out_valid0, out_bit0, out_last0, busy0});
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      int b = beats0;
      send0(8'hA5);
      @(negedge clk);
      n_checks++;
      if (in_ready0 !== 1'b0 || busy0 !== 1'b1) begin
         n_fail++;
         $display("FAIL shift_ready: got in_ready=%b busy=%b want 0 1", in_ready0, busy0);
      end
      wait_idle(0);
      n_checks++;
      if (beats0 - b !== 9 || last_par0 !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_frame: got beats=%0d par=%b want 9 0", beats0 - b, last_par0);
      end
      send0(8'h01);
      wait_idle(0);
      n_checks++;
      if (last_par0 !== 1'b1) begin n_fail++; $display("FAIL even_01: got par=%b want 1", last_par0); end
   endtask

   task automatic test_odd;
      send1(8'hA5);
      wait_idle(1);
      n_checks++;
      if (last_par1 !== 1'b1) begin n_fail++; $display("FAIL odd_A5: got par=%b want 1", last_par1); end
      send1(8'h00);
      wait_idle(1);
      n_checks++;
      if (last_par1 !== 1'b1) begin n_fail++; $display("FAIL odd_00: got par=%b want 1", last_par1); end
   endtask

   task automatic test_back_to_back;
      int v = 0;
      in_data0 = 8'hFF;
      in_valid0 = 1;
      @(negedge clk);
      @(posedge clk); #1 in_data0 = 8'h00;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (out_valid0) v++;
         if (i == 8) begin
            n_checks++;
            if (in_ready0 !== 1'b1 || out_last0 !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_accept: got in_ready=%b last=%b want 1 1", in_ready0, out_last0);
            end
            @(posedge clk); #1 in_valid0 = 0;
         end
      end
      n_checks++;
      if (v !== 18) begin n_fail++; $display("FAIL b2b_gapless: got %0d valid beats want 18", v); end
      wait_idle(0);
      n_checks++;
      if (last_par0 !== 1'b0) begin n_fail++; $display("FAIL b2b_par: got %b want 0", last_par0); end
   endtask

   task automatic test_backpressure;
      int b = beats0;
      int n = 0;
      in_data0 = 8'h3C;
      in_valid0 = 1;
      @(negedge clk);
      @(posedge clk); #1 in_valid0 = 0;
      while (beats0 - b < 9 && n < 500) begin
         out_ready0 = $urandom_range(0, 2) == 0;
         @(posedge clk); #1;
         n++;
      end
      out_ready0 = 1;
      wait_idle(0);
      n_checks++;
      if (beats0 - b !== 9 || last_par0 !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_frame: got beats=%0d par=%b want 9 0", beats0 - b, last_par0);
      end
   endtask

   task automatic test_reset_mid;
      int b = beats0;
      int n = 0;
      send0(8'hA5);
      while (beats0 - b < 3 && n < 50) begin @(posedge clk); n++; end
      #2 rst_n = 0;
      #1;
      n_checks++;
      if (out_valid0 !== 1'b0 || busy0 !== 1'b0 || in_ready0 !== 1'b1) begin
         n_fail++;
         $display("FAIL async_abort: got valid=%b busy=%b in_ready=%b want 0 0 1", out_valid0, busy0, in_ready0);
      end
      sb0.delete();
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      b = beats0;
      send0(8'h01);
      wait_idle(0);
      n_checks++;
      if (beats0 - b !== 9 || last_par0 !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset: got beats=%0d par=%b want 9 1", beats0 - b, last_par0);
      end
   endtask

   task automatic test_width2;
      int b = beats2;
      send2(2'b11);
      wait_idle(2);
      n_checks++;
      if (beats2 - b !== 3 || last_par2 !== 1'b0) begin
         n_fail++;
         $display("FAIL w2_11: got beats=%0d par=%b want 3 0", beats2 - b, last_par2);
      end
      send2(2'b10);
      wait_idle(2);
      n_checks++;
      if (beats2 - b !== 6 || last_par2 !== 1'b1) begin
         n_fail++;
         $display("FAIL w2_10: got beats=%0d par=%b want 6 1", beats2 - b, last_par2);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_odd;
      test_back_to_back;
      test_backpressure;
      test_reset_mid;
      test_width2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
